sdp_ram_reader: RTL and testbench
=================================

# sdp_ram_reader

Streaming read-side controller for a simple dual-port RAM's read port (addrb/reb/doutb). It accepts read addresses over a valid/ready request channel and drives the RAM read port. It tracks the RAM's fixed read latency and returns data over a valid/ready response channel, with full backpressure support. A credit-limited output buffer guarantees no RAM result is ever dropped, while sustaining one read per cycle when the consumer is always ready.

## Interface

Parameters:
- DATA_W, 32, data width; must match the RAM.
- DEPTH_W, 8, RAM address width.
- LATENCY, 2, RAM read latency in cycles. 1 = raw-output RAM, 2 = registered-output RAM. Other values are illegal.
- Derived: BUF_DEPTH = LATENCY+1 entries; counter width CNT_W = clog2(BUF_DEPTH+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high. The same rst drives the attached RAM.
- s_valid  in  1  read request valid.
- s_ready  out  1  request accepted when s_valid & s_ready.
- s_addr  in  DEPTH_W  read address.
- ram_reb  out  1  RAM read enable.
- ram_addrb  out  DEPTH_W  RAM read address.
- ram_doutb  in  DATA_W  RAM read data.
- m_valid  out  1  response valid.
- m_ready  in  1  consumer ready.
- m_data  out  DATA_W  response data; held stable while m_valid & !m_ready.
- busy  out  1  high while any read is in flight or buffered.

## Operation

- Definitions: accept = s_valid & s_ready; pop = m_valid & m_ready.
- Issue path is combinational: ram_reb = accept; ram_addrb = s_addr.
- A LATENCY-stage valid shift register tracks issued reads. Stage 0 loads accept. When the last stage is high, ram_doutb is written into the output FIFO at that edge.
- Output FIFO holds BUF_DEPTH entries of DATA_W, with circular read/write pointers that wrap at BUF_DEPTH.
  - m_valid = occupancy != 0.
  - m_data = FIFO head.
  - No bypass: capture and output never occur in the same cycle.
- Credit rule:
  - in_flight counts the high bits in the shift register; occ is the FIFO occupancy.
  - s_ready = !rst & ((in_flight + occ - pop) < BUF_DEPTH).
  - Computed at CNT_W+1 bits, so the subtraction cannot underflow.
  - The rule guarantees a FIFO slot exists for every in-flight read, so overflow is impossible by construction.
- Simultaneous capture and pop: occupancy is unchanged and both pointers advance.
- Responses are returned strictly in request order.
- Read-during-write to the same address (write port driven elsewhere) returns pre-write data. The block performs no hazard detection.
- busy = (in_flight != 0) | (occ != 0).
- Reset (asynchronous, any time, including mid-burst):
  - Clears the shift register, pointers and occupancy; in-flight reads are discarded.
  - While rst is high: s_ready=0, ram_reb=0, m_valid=0, m_data=0, busy=0.
  - FIFO storage need not be cleared; m_data is masked to 0 while empty.

## Timing

- Request accepted in cycle t: RAM data is captured at the end of cycle t+LATENCY, so m_valid rises in cycle t+LATENCY+1. Request-to-response latency is LATENCY+1 cycles.
- With m_ready held high and s_valid held high: one accept and one pop per cycle indefinitely. Steady state is in_flight=LATENCY, occ=1.
- With m_ready held low: at most BUF_DEPTH requests are accepted, then s_ready=0. Everything accepted before the stall is retained.
- s_ready falls in the cycle the credit is exhausted.
- s_ready rises combinationally in the same cycle m_ready frees a slot. The m_ready->s_ready combinational path is intended.
- Capture with a full FIFO never occurs; the bench asserts this.
- First cycle after rst deasserts: s_ready=1 and the block is idle.

## Test plan

- Streaming (LATENCY=2): RAM preloaded MEM[i]=i*3. Addresses 0..15 issued back-to-back, m_ready=1. Required: m_data=0,3,...,45 on 16 consecutive cycles; first m_valid 3 cycles after the first accept; s_ready never low.
- Backpressure: m_ready=0, s_valid held with addresses 5,6,7,8. Required: exactly 3 accepts (BUF_DEPTH=3), then s_ready=0. Raise m_ready: data MEM[5],MEM[6],MEM[7],MEM[8] in order, with no loss or duplication.
- LATENCY=1 build: single read of addr 0x2A, with MEM[0x2A]=0xDEADBEEF. Required: m_valid exactly 2 cycles after accept, m_data=0xDEADBEEF; BUF_DEPTH=2 limit holds under m_ready=0.
- Random throttle: random s_valid and m_ready, 1000 requests. Required: a scoreboard matches every response in order; occupancy never exceeds BUF_DEPTH; capture never occurs into a full FIFO.
- Reset mid-burst: assert rst with 2 in flight and 1 buffered. Required: the same cycle drives m_valid=0, s_ready=0, busy=0. After release no stale response appears; a new read of addr 1 returns MEM[1] only.
- Read-during-write: write MEM[4]=0x11 (old value 0x00) in the same cycle a read of 4 is accepted. Required: response 0x00; the next read of 4 returns 0x11.

Source files
------------

// File: rtl/sdp_ram_reader.sv
// sdp_ram_reader: read-side controller for a simple dual-port RAM.
// Ports: clk, rst (async, active-high); request s_valid/s_ready/s_addr;
//   RAM read port ram_reb/ram_addrb/ram_doutb; response m_valid/m_ready/m_data;
//   busy (reads in flight or buffered).
module sdp_ram_reader #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 8,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DEPTH_W-1:0] s_addr,
    output logic               ram_reb,
    output logic [DEPTH_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0]  ram_doutb,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic               busy
);

    localparam int BUF_DEPTH = LATENCY + 1;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W     = $clog2(BUF_DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W:0]   CREDITS  = (CNT_W+1)'(BUF_DEPTH);

    logic [LATENCY-1:0] r_vld;
    logic [DATA_W-1:0]  r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_occ;

    logic               w_accept;
    logic               w_pop;
    logic               w_cap;
    logic               w_nonempty;
    logic [CNT_W-1:0]   w_in_flight;
    logic [CNT_W:0]     w_committed;

    // Popcount of the latency pipe: reads issued but not yet captured.
    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_in_flight = w_in_flight + CNT_W'(r_vld[i]);
        end
    end

    assign w_nonempty = (r_occ != '0);
    assign w_cap      = r_vld[LATENCY-1];
    assign m_valid    = !rst & w_nonempty;
    assign w_pop      = m_valid & m_ready;

    // Every issued read owns a FIFO slot from issue until pop, so the
    // FIFO can never overflow. A slot freed by this cycle's pop is
    // reusable at once, hence the m_ready -> s_ready path.
    assign w_committed = {1'b0, w_in_flight}
                       + {1'b0, r_occ}
                       - {{CNT_W{1'b0}}, w_pop};

    assign s_ready   = !rst & (w_committed < CREDITS);
    assign w_accept  = s_valid & s_ready;

    assign ram_reb   = w_accept;
    assign ram_addrb = s_addr;

    // Storage is masked while empty, so it needs no reset.
    assign m_data = m_valid ? r_mem[r_rptr] : '0;

    assign busy = !rst & ((w_in_flight != '0) | w_nonempty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_mem[r_wptr] <= ram_doutb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_cap) begin
            r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
        end
    end

    // Capture and pop together leave the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            unique case ({w_cap, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_ram_reader.sv
// tb_sdp_ram_reader: LATENCY=2 instance against a queue-based reference,
// plus a LATENCY=1 instance with directed timing and credit checks.
module tb_sdp_ram_reader;

    localparam int BUF2 = 3;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        s_valid, s_ready, ram_reb, m_valid, m_ready, busy;
    logic [7:0]  s_addr, ram_addrb;
    logic [31:0] ram_doutb, m_data;

    logic        l1_s_valid, l1_s_ready, l1_reb, l1_m_valid, l1_m_ready, l1_busy;
    logic [7:0]  l1_s_addr, l1_addrb;
    logic [31:0] l1_doutb, l1_m_data;

    logic        we, l1_we;
    logic [7:0]  waddr, l1_waddr;
    logic [31:0] wdata, l1_wdata;

    logic [31:0] mem2 [256];
    logic [31:0] mem1 [256];
    logic [31:0] q1, q2, l1_q;

    sdp_ram_reader #(.DATA_W(32), .DEPTH_W(8), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .ram_reb(ram_reb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy)
    );

    sdp_ram_reader #(.DATA_W(32), .DEPTH_W(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .s_valid(l1_s_valid), .s_ready(l1_s_ready), .s_addr(l1_s_addr),
        .ram_reb(l1_reb), .ram_addrb(l1_addrb), .ram_doutb(l1_doutb),
        .m_valid(l1_m_valid), .m_ready(l1_m_ready), .m_data(l1_m_data),
        .busy(l1_busy)
    );

    // Registered-output RAM, read-before-write.
    always @(posedge clk) begin
        if (we) mem2[waddr] <= wdata;
        if (ram_reb) q1 <= mem2[ram_addrb];
        q2 <= q1;
    end
    assign ram_doutb = q2;

    // Raw-output RAM.
    always @(posedge clk) begin
        if (l1_we) mem1[l1_waddr] <= l1_wdata;
        if (l1_reb) l1_q <= mem1[l1_addrb];
    end
    assign l1_doutb = l1_q;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        int          t;
    } exp_t;

    exp_t        exq [$];
    int          pop_t [$];
    logic [31:0] pop_d [$];
    int          acc_t [$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;

    // Reference: each accepted read becomes visible LATENCY+1 cycles
    // later, in order; credits are BUF_DEPTH reads not yet popped.
    always @(negedge clk) begin
        bit hv, ep, er, acc, pop;
        int vis;
        cyc++;
        if (rst) begin
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_m_data", m_data, 32'd0);
            check("rst_s_ready", 32'(s_ready), 32'd0);
            check("rst_ram_reb", 32'(ram_reb), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            exq.delete();
        end else begin
            hv = (exq.size() != 0) && (exq[0].t <= cyc);
            ep = hv && m_ready;
            er = (exq.size() - int'(ep)) < BUF2;
            check("m_valid", 32'(m_valid), 32'(hv));
            check("m_data", m_data, hv ? exq[0].d : 32'd0);
            check("s_ready", 32'(s_ready), 32'(er));
            check("busy", 32'(busy), 32'(exq.size() != 0));
            check("ram_reb", 32'(ram_reb), 32'(s_valid && er));
            acc = s_valid && s_ready;
            pop = m_valid && m_ready;
            if (acc) check("ram_addrb", 32'(ram_addrb), 32'(s_addr));
            if (pop) begin
                pop_cnt++;
                pop_t.push_back(cyc);
                pop_d.push_back(m_data);
                if (exq.size() != 0) void'(exq.pop_front());
            end
            if (acc) begin
                exq.push_back('{d: mem2[s_addr], t: cyc + 3});
                acc_t.push_back(cyc);
                acc_cnt++;
            end
            vis = 0;
            foreach (exq[i]) if (exq[i].t <= cyc + 1) vis++;
            check("occ_le_buf", 32'(vis <= BUF2), 32'd1);
            check("cap_not_full", 32'(exq.size() <= BUF2), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        s_valid = 1'b1;
        s_addr = a;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = s_ready;
            if (!ok) waits++;
            step();
        end
        s_valid = 1'b0;
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 40 && exq.size() != 0; k++) step();
        step();
        check("drain", 32'(exq.size()), 32'd0);
    endtask

    task automatic clear_logs();
        pop_t.delete();
        pop_d.delete();
        acc_t.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=%0d exp=done", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int w, stalls, idx, n, g, start;
        int ba [4];
        ba = '{5, 6, 7, 8};
        rst = 1'b1;
        s_valid = 1'b0; s_addr = '0; m_ready = 1'b0;
        l1_s_valid = 1'b0; l1_s_addr = '0; l1_m_ready = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        l1_we = 1'b0; l1_waddr = '0; l1_wdata = '0;
        #1;
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 8'(i); wdata = 32'(i * 3);
            step();
        end
        we = 1'b0;
        l1_we = 1'b1; l1_waddr = 8'h2A; l1_wdata = 32'hDEADBEEF;
        step();
        l1_we = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(s_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        step();

        // Streaming
        clear_logs();
        m_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            issue(8'(i), w);
            stalls += w;
        end
        drain();
        check("strm_stalls", 32'(stalls), 32'd0);
        check("strm_count", 32'(pop_d.size()), 32'd16);
        for (int i = 0; i < 16 && i < pop_d.size(); i++) begin
            check("strm_data", pop_d[i], 32'(i * 3));
            check("strm_gap", 32'(pop_t[i] - pop_t[0]), 32'(i));
        end
        if (pop_t.size() != 0 && acc_t.size() != 0)
            check("strm_lat", 32'(pop_t[0] - acc_t[0]), 32'd3);

        // Backpressure
        clear_logs();
        m_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            s_valid = (idx < 4);
            s_addr = 8'(ba[idx < 4 ? idx : 3]);
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            step();
        end
        check("bp_accepts", 32'(idx), 32'd3);
        check("bp_s_ready", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            s_valid = 1'b1;
            s_addr = 8'(ba[idx < 4 ? idx : 3]);
            @(negedge clk);
            if (s_ready) idx++;
            step();
        end
        drain();
        check("bp_count", 32'(pop_d.size()), 32'd4);
        for (int i = 0; i < 4 && i < pop_d.size(); i++)
            check("bp_data", pop_d[i], 32'(ba[i] * 3));

        // Random throttle
        start = acc_cnt;
        n = pop_cnt;
        g = 0;
        while (acc_cnt < start + 1000 && g < 20000) begin
            s_valid = ($urandom % 3) != 0;
            s_addr = 8'($urandom);
            m_ready = ($urandom % 4) != 0;
            step();
            g++;
        end
        drain();
        check("rnd_accepts", 32'(acc_cnt - start), 32'd1000);
        check("rnd_pops", 32'(pop_cnt - n), 32'd1000);

        // Reset mid-burst: 2 in flight, 1 buffered
        m_ready = 1'b0;
        issue(8'd2, w);
        issue(8'd3, w);
        issue(8'd4, w);
        check("pre_rst_m_valid", 32'(m_valid), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        s_valid = 1'b1;
        s_addr = 8'd9;
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_reb", 32'(ram_reb), 32'd0);
        step();
        step();
        s_valid = 1'b0;
        rst = 1'b0;
        clear_logs();
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("no_stale", 32'(pop_d.size()), 32'd0);
        issue(8'd1, w);
        drain();
        check("rst_new_count", 32'(pop_d.size()), 32'd1);
        if (pop_d.size() != 0) check("rst_new_data", pop_d[0], 32'd3);

        // Read-during-write
        clear_logs();
        we = 1'b1; waddr = 8'd4; wdata = 32'h0;
        step();
        wdata = 32'h11;
        issue(8'd4, w);
        we = 1'b0;
        drain();
        issue(8'd4, w);
        drain();
        check("rdw_count", 32'(pop_d.size()), 32'd2);
        if (pop_d.size() == 2) begin
            check("rdw_old", pop_d[0], 32'h0);
            check("rdw_new", pop_d[1], 32'h11);
        end

        // LATENCY=1 instance
        l1_m_ready = 1'b1;
        l1_s_valid = 1'b1;
        l1_s_addr = 8'h2A;
        @(negedge clk);
        check("l1_accept", 32'(l1_s_ready), 32'd1);
        step();
        l1_s_valid = 1'b0;
        @(negedge clk);
        check("l1_mv_t1", 32'(l1_m_valid), 32'd0);
        step();
        @(negedge clk);
        check("l1_mv_t2", 32'(l1_m_valid), 32'd1);
        check("l1_data", l1_m_data, 32'hDEADBEEF);
        step();
        l1_m_ready = 1'b0;
        l1_s_valid = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (l1_s_ready) n++;
            step();
        end
        l1_s_valid = 1'b0;
        check("l1_accepts", 32'(n), 32'd2);
        @(negedge clk);
        check("l1_s_ready", 32'(l1_s_ready), 32'd0);
        step();
        l1_m_ready = 1'b1;
        @(negedge clk);
        check("l1_bp_data", l1_m_data, 32'hDEADBEEF);
        for (int k = 0; k < 10 && l1_busy; k++) step();
        check("l1_idle", 32'(l1_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
